// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer.
// One shared 4-bit ripple adder, LSB nibble first.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  // carry chain through four full adders
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i])
             | (a[i] & c[i])
             | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_s;
  logic             sl_c;
  logic             accept;
  logic             last;
  logic             ovf_nxt;

  // current nibble of each operand
  always_comb begin
    a_sh = a_reg >> {idx, 2'b00};
    b_sh = b_reg >> {idx, 2'b00};
    sl_a = a_sh[3:0];
    sl_b = b_sh[3:0];
  end

  ripple_carry_adder u_rca (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_reg),
    .s    (sl_s),
    .cout (sl_c)
  );

  // signed overflow from operand signs vs top slice sign
  always_comb begin
    ovf_nxt =
      (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
      (sl_s[3] != a_reg[WIDTH-1]);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        last = (idx == LAST);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture and per-nibble datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      idx       <= '0;
      sum_reg   <= '0;
    end else if (state == RUN) begin
      sum_reg[{idx, 2'b00} +: 4] <= sl_s;
      carry_reg <= sl_c;
      idx       <= idx + 1'b1;
      if (last) begin
        cout_reg <= sl_c;
        ovf_reg  <= ovf_nxt;
      end
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl.
// Hand-computed vectors, WIDTH=16.

module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // count edges until out_valid, 0 on timeout
  task automatic wait_out(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic offer(
    input logic [15:0] ta,
    input logic [15:0] tb,
    input logic        tc,
    input logic        ts
  );
    a        = ta;
    b        = tb;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(
    input string       tag,
    input logic [15:0] ta,
    input logic [15:0] tb,
    input logic        tc,
    input logic        ts,
    input logic [15:0] es,
    input logic        ec,
    input logic        eo
  );
    int lat;
    check({tag, "_rdy"}, in_ready, 1);
    offer(ta, tb, tc, ts);
    wait_out(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov0"}, out_valid, 0);
    check({tag, "_hold"}, sum, es);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    check("rst_ir", in_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("add", 16'h1234, 16'h4321,
           0, 0, 16'h5555, 0, 0);
    run_op("ripple", 16'hFFFF, 16'h0001,
           0, 0, 16'h0000, 1, 0);
    run_op("cin", 16'h000F, 16'h0000,
           1, 0, 16'h0010, 0, 0);
    run_op("ovfadd", 16'h7FFF, 16'h0001,
           0, 0, 16'h8000, 0, 1);
    run_op("ovfsub", 16'h8000, 16'h0001,
           0, 1, 16'h7FFF, 1, 1);
    run_op("borrow", 16'h0005, 16'h0007,
           1, 1, 16'hFFFE, 0, 0);

    // backpressure with a pending operand
    offer(16'h1234, 16'h4321, 0, 0);
    wait_out(lat);
    check("bp_lat", lat, 4);
    a        = 16'h0005;
    b        = 16'h0007;
    cin      = 1'b1;
    sub      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_sum", sum, 16'h5555);
      check("bp_cout", cout, 0);
      check("bp_ovf", overflow, 0);
      check("bp_ir", in_ready, 0);
      check("bp_ov", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_ir", in_ready, 1);
    check("bp_idle_ov", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_acc", in_ready, 0);
    wait_out(lat);
    check("bp2_lat", lat, 4);
    check("bp2_sum", sum, 16'hFFFE);
    check("bp2_cout", cout, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // asynchronous reset in the second RUN cycle
    offer(16'h1234, 16'h4321, 0, 0);
    @(posedge clk);
    #1;
    check("mid_sum", sum, 16'h0005);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ov", out_valid, 0);
    check("arst_ir", in_ready, 1);
    check("arst_sum", sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("post", 16'h0001, 16'h0001,
           0, 0, 16'h0002, 0, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
